sum_stage: RTL and testbench

Third arithmetic stage of the PE row pipeline, and the receiving end of the MS rdy/ack channel driven by the multiply stage. Each accepted beat adds the per-row products `Sum_MS` to either the forwarded partial sums `Psum_MS` or a local per-row accumulator. The pipelined `SSctl` word selects the source and whether the beat is emitted. Emitted results are held in a one-entry output register and offered on the SS rdy/ack channel to the psum writeback.

---
 rtl/sum_stage_pkg.sv | 24 ++
 rtl/sum_stage_sat_add.sv | 29 ++
 rtl/sum_stage.sv | 77 +++++++
 tb/tb_sum_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sum_stage_pkg.sv
// Shared configuration and control/data typedefs for the PE row pipeline sum stage.
package PECfg;
  localparam int PEROW   = 4;
  localparam int DWD     = 8;
  localparam int PSUMDWD = 16;
endpackage

package PECtlCfg;
  typedef struct packed {
    logic acc_src;
    logic emit;
  } SSctl;

  typedef struct packed {
    logic signed [PECfg::PSUMDWD-1:0] Psum_MS;
    logic signed [PECfg::DWD-1:0]     Sum_MS;
  } MSout;

  typedef struct packed {
    logic signed [PECfg::PSUMDWD-1:0] Psum_SS;
  } SSout;

  typedef enum logic {SS_EMPTY = 1'b0, SS_FULL = 1'b1} ss_state_e;
endpackage

// File: rtl/sum_stage_sat_add.sv
// Single-row signed adder: PSUMDWD addend plus sign-extended DWD product.
// SUMSTAGE_SAT_EN selects saturating arithmetic with an overflow flag; otherwise wraps.
module sat_add #(
  parameter int DWD     = 8,
  parameter int PSUMDWD = 16
) (
  input  logic [PSUMDWD-1:0] a,
  input  logic [DWD-1:0]     b,
  output logic [PSUMDWD-1:0] sum,
  output logic               ovf
);
`ifdef SUMSTAGE_SAT_EN
  logic [PSUMDWD:0] wide;
  assign wide = {a[PSUMDWD-1], a} + {{(PSUMDWD-DWD+1){b[DWD-1]}}, b};

  // Top two bits disagree only when the true sum left the PSUMDWD range.
  always_comb begin
    sum = wide[PSUMDWD-1:0];
    ovf = 1'b0;
    if (wide[PSUMDWD] != wide[PSUMDWD-1]) begin
      ovf = 1'b1;
      sum = wide[PSUMDWD] ? {1'b1, {(PSUMDWD-1){1'b0}}} : {1'b0, {(PSUMDWD-1){1'b1}}};
    end
  end
`else
  assign sum = a + {{(PSUMDWD-DWD){b[DWD-1]}}, b};
  assign ovf = 1'b0;
`endif
endmodule

// File: rtl/sum_stage.sv
// PE row sum stage: MS rdy/ack sink, per-row accumulate/emit, one-entry SS output register.
// SUMSTAGE_SAT_EN enables saturating sums and sticky per-row o_ovf flags.
module sum_stage
  import PECtlCfg::*;
#(
  parameter int PEROW   = PECfg::PEROW,
  parameter int DWD     = PECfg::DWD,
  parameter int PSUMDWD = PECfg::PSUMDWD
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   MS_rdy,
  output logic                   MS_ack,
  input  MSout [PEROW-1:0]       i_data,
  input  SSctl                   i_SSpipe_MS,
  output logic                   SS_rdy,
  input  logic                   SS_ack,
  output SSout [PEROW-1:0]       o_data,
  output logic [PEROW-1:0]       o_ovf
);
  ss_state_e                       state;
  logic [PEROW-1:0][PSUMDWD-1:0]   acc, addend, sum;
  logic [PEROW-1:0]                row_ovf;
  logic                            xfer, emit_xfer, en;

  assign MS_ack    = MS_rdy && (!i_SSpipe_MS.emit || state == SS_EMPTY || SS_ack);
  assign xfer      = MS_rdy && MS_ack;
  assign emit_xfer = xfer && i_SSpipe_MS.emit;
  assign en        = xfer || (SS_ack && state == SS_FULL);
  assign SS_rdy    = (state == SS_FULL);

  for (genvar r = 0; r < PEROW; r++) begin : g_row
    assign addend[r] = i_SSpipe_MS.acc_src ? acc[r] : i_data[r].Psum_MS;
    sat_add #(.DWD(DWD), .PSUMDWD(PSUMDWD)) u_add (
      .a   (addend[r]),
      .b   (i_data[r].Sum_MS),
      .sum (sum[r]),
      .ovf (row_ovf[r])
    );
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= SS_EMPTY;
      o_data <= '0;
      acc    <= '0;
    end else if (en) begin
      if (xfer) begin
        for (int r = 0; r < PEROW; r++) begin
          if (i_SSpipe_MS.emit) begin
            o_data[r].Psum_SS <= sum[r];
            acc[r]            <= '0;
          end else begin
            acc[r] <= sum[r];
          end
        end
      end
      case (state)
        SS_EMPTY: if (emit_xfer) state <= SS_FULL;
        SS_FULL:  if (SS_ack && !emit_xfer) state <= SS_EMPTY;
        default:  state <= SS_EMPTY;
      endcase
    end
  end

`ifdef SUMSTAGE_SAT_EN
  // Flags only count on accepted beats; a stalled beat's sum is never committed.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)   o_ovf <= '0;
    else if (xfer) o_ovf <= o_ovf | row_ovf;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ^row_ovf;
  assign o_ovf      = '0;
`endif
endmodule

// File: tb/tb_sum_stage.sv
// Randomized self-checking bench for sum_stage against a per-row integer reference model.
module tb_sum_stage;
  import PECtlCfg::*;
  localparam int PEROW   = PECfg::PEROW;
  localparam int DWD     = PECfg::DWD;
  localparam int PSUMDWD = PECfg::PSUMDWD;

  logic             i_clk = 1'b0;
  logic             i_rstn = 1'b0;
  logic             MS_rdy = 1'b0, MS_ack, SS_rdy, SS_ack = 1'b0;
  MSout [PEROW-1:0] i_data = '0;
  SSctl             ctl = '0;
  SSout [PEROW-1:0] o_data;
  logic [PEROW-1:0] o_ovf;

  sum_stage #(.PEROW(PEROW), .DWD(DWD), .PSUMDWD(PSUMDWD)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .MS_rdy(MS_rdy), .MS_ack(MS_ack),
    .i_data(i_data), .i_SSpipe_MS(ctl), .SS_rdy(SS_rdy), .SS_ack(SS_ack),
    .o_data(o_data), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0;
  int ps_in [PEROW];
  int sm_in [PEROW];
  int acc_m [PEROW];
  int od_m  [PEROW];
  bit [PEROW-1:0] ovf_m;
  bit full_m;
  bit ack_obs, ack_exp;

  // Reference arithmetic: exact integer sum, then clamp or wrap into PSUMDWD.
  function automatic int fit(input int v, output bit o);
    int lim;
    lim = 1 << (PSUMDWD-1);
    o = 1'b0;
`ifdef SUMSTAGE_SAT_EN
    if (v > lim-1) begin v = lim-1; o = 1'b1; end
    else if (v < -lim) begin v = -lim; o = 1'b1; end
`else
    v = ((v + lim) % (2*lim) + 2*lim) % (2*lim) - lim;
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < PEROW; r++) begin acc_m[r] = 0; od_m[r] = 0; end
    ovf_m = '0; full_m = 1'b0;
  endtask

  task automatic rand_rows();
    for (int r = 0; r < PEROW; r++) begin
      ps_in[r] = int'($signed(16'($urandom)));
      sm_in[r] = int'($signed(8'($urandom)));
    end
  endtask

  // Drive one cycle, capture MS_ack before the edge, advance the model at the edge.
  task automatic cycle(input bit rdy, input bit ack, input bit src, input bit emit);
    bit xf, o;
    int s;
    MS_rdy = rdy; SS_ack = ack; ctl.acc_src = src; ctl.emit = emit;
    for (int r = 0; r < PEROW; r++) begin
      i_data[r].Psum_MS = PSUMDWD'(ps_in[r]);
      i_data[r].Sum_MS  = DWD'(sm_in[r]);
    end
    #1;
    ack_obs = MS_ack;
    ack_exp = rdy && (!emit || !full_m || ack);
    @(posedge i_clk);
    xf = rdy && ack_exp;
    if (xf) begin
      for (int r = 0; r < PEROW; r++) begin
        s = fit(sm_in[r] + (src ? acc_m[r] : ps_in[r]), o);
        if (o) ovf_m[r] = 1'b1;
        if (emit) begin od_m[r] = s; acc_m[r] = 0; end
        else acc_m[r] = s;
      end
    end
    if (xf && emit) full_m = 1'b1;
    else if (ack) full_m = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    MS_rdy = 1'b1; ctl.emit = 1'b1; ctl.acc_src = 1'b0;
    #1;
    total++; if (SS_rdy !== 1'b0) begin bad++; $display("FAIL reset_ss_rdy got=%b exp=0", SS_rdy); end
    total++; if (o_data !== '0) begin bad++; $display("FAIL reset_o_data got=%h exp=0", o_data); end
    total++; if (o_ovf !== '0) begin bad++; $display("FAIL reset_o_ovf got=%b exp=0", o_ovf); end
    total++; if (MS_ack !== 1'b1) begin bad++; $display("FAIL reset_ms_ack got=%b exp=1", MS_ack); end
    MS_rdy = 1'b0;
    #11 i_rstn = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_pass_through();
    rand_rows();
    ps_in[0] = 100; sm_in[0] = -3;
    cycle(1, 0, 0, 1);
    total++; if (ack_obs !== 1'b1) begin bad++; $display("FAIL pass_ms_ack got=%b exp=1", ack_obs); end
    total++; if (SS_rdy !== 1'b1) begin bad++; $display("FAIL pass_ss_rdy got=%b exp=1", SS_rdy); end
    total++; if (o_data[0].Psum_SS !== 16'sd97) begin bad++; $display("FAIL pass_row0 got=%0d exp=97", o_data[0].Psum_SS); end
    for (int r = 0; r < PEROW; r++) begin
      total++; if (o_data[r].Psum_SS !== PSUMDWD'(od_m[r])) begin bad++; $display("FAIL pass_row%0d got=%0d exp=%0d", r, o_data[r].Psum_SS, od_m[r]); end
    end
    cycle(0, 1, 0, 0);
    total++; if (SS_rdy !== 1'b0) begin bad++; $display("FAIL pass_drain got=%b exp=0", SS_rdy); end
  endtask

  task automatic test_accumulate();
    int vals [3];
    vals = '{5, 7, -2};
    for (int i = 0; i < 3; i++) begin
      rand_rows();
      for (int r = 0; r < PEROW; r++) sm_in[r] = vals[i];
      cycle(1, 0, 1, i == 2);
      total++; if (SS_rdy !== (i == 2)) begin bad++; $display("FAIL acc_beat%0d_ss_rdy got=%b exp=%b", i, SS_rdy, i == 2); end
    end
    for (int r = 0; r < PEROW; r++) begin
      total++; if (o_data[r].Psum_SS !== 16'sd10) begin bad++; $display("FAIL acc_row%0d got=%0d exp=10", r, o_data[r].Psum_SS); end
    end
    // Zero product on the accumulator exposes its value: must be cleared.
    for (int r = 0; r < PEROW; r++) sm_in[r] = 0;
    cycle(1, 1, 1, 1);
    for (int r = 0; r < PEROW; r++) begin
      total++; if (o_data[r].Psum_SS !== 16'sd0) begin bad++; $display("FAIL acc_cleared_row%0d got=%0d exp=0", r, o_data[r].Psum_SS); end
    end
    cycle(0, 1, 0, 0);
  endtask

  task automatic test_backpressure();
    rand_rows(); cycle(1, 0, 0, 1);
    rand_rows(); cycle(1, 0, 0, 1);
    total++; if (ack_obs !== 1'b0) begin bad++; $display("FAIL bp_emit_ack got=%b exp=0", ack_obs); end
    total++; if (SS_rdy !== 1'b1) begin bad++; $display("FAIL bp_ss_rdy got=%b exp=1", SS_rdy); end
    for (int r = 0; r < PEROW; r++) begin
      total++; if (o_data[r].Psum_SS !== PSUMDWD'(od_m[r])) begin bad++; $display("FAIL bp_hold_row%0d got=%0d exp=%0d", r, o_data[r].Psum_SS, od_m[r]); end
    end
    rand_rows(); cycle(1, 0, 0, 0);
    total++; if (ack_obs !== 1'b1) begin bad++; $display("FAIL bp_nonemit_ack got=%b exp=1", ack_obs); end
  endtask

  task automatic test_simultaneous();
    rand_rows(); cycle(1, 1, 1, 1);
    total++; if (ack_obs !== 1'b1) begin bad++; $display("FAIL sim_ack got=%b exp=1", ack_obs); end
    total++; if (SS_rdy !== 1'b1) begin bad++; $display("FAIL sim_ss_rdy got=%b exp=1", SS_rdy); end
    for (int r = 0; r < PEROW; r++) begin
      total++; if (o_data[r].Psum_SS !== PSUMDWD'(od_m[r])) begin bad++; $display("FAIL sim_row%0d got=%0d exp=%0d", r, o_data[r].Psum_SS, od_m[r]); end
    end
    cycle(0, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      rand_rows(); cycle(1, 1, 0, 1);
      total++; if (ack_obs !== 1'b1 || SS_rdy !== 1'b1) begin bad++; $display("FAIL b2b%0d ack=%b rdy=%b exp=1,1", i, ack_obs, SS_rdy); end
      total++; if (o_data[1].Psum_SS !== PSUMDWD'(od_m[1])) begin bad++; $display("FAIL b2b%0d_row1 got=%0d exp=%0d", i, o_data[1].Psum_SS, od_m[1]); end
    end
    cycle(0, 1, 0, 0);
  endtask

  task automatic test_saturation();
    logic signed [PSUMDWD-1:0] exp0;
`ifdef SUMSTAGE_SAT_EN
    exp0 = 16'sd32767;
`else
    exp0 = -16'sd32676;
`endif
    rand_rows();
    ps_in[0] = 32760; sm_in[0] = 100;
    cycle(1, 0, 0, 1);
    total++; if (o_data[0].Psum_SS !== exp0) begin bad++; $display("FAIL sat_row0 got=%0d exp=%0d", o_data[0].Psum_SS, exp0); end
    total++; if (o_ovf !== ovf_m) begin bad++; $display("FAIL sat_ovf got=%b exp=%b", o_ovf, ovf_m); end
`ifdef SUMSTAGE_SAT_EN
    total++; if (o_ovf[0] !== 1'b1) begin bad++; $display("FAIL sat_ovf0 got=%b exp=1", o_ovf[0]); end
`else
    total++; if (o_ovf !== '0) begin bad++; $display("FAIL sat_ovf_off got=%b exp=0", o_ovf); end
`endif
    for (int r = 0; r < PEROW; r++) begin ps_in[r] = 1; sm_in[r] = 1; end
    cycle(1, 1, 0, 1);
    total++; if (o_ovf !== ovf_m) begin bad++; $display("FAIL sat_ovf_sticky got=%b exp=%b", o_ovf, ovf_m); end
    cycle(0, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_rows();
      cycle(($urandom % 4) != 0, ($urandom % 3) != 0, $urandom % 2, ($urandom % 3) == 0);
      total++; if (ack_obs !== ack_exp) begin bad++; $display("FAIL rnd%0d_ack got=%b exp=%b", i, ack_obs, ack_exp); end
      total++; if (SS_rdy !== full_m) begin bad++; $display("FAIL rnd%0d_ss_rdy got=%b exp=%b", i, SS_rdy, full_m); end
      total++; if (o_ovf !== ovf_m) begin bad++; $display("FAIL rnd%0d_ovf got=%b exp=%b", i, o_ovf, ovf_m); end
      for (int r = 0; r < PEROW; r++) begin
        total++; if (o_data[r].Psum_SS !== PSUMDWD'(od_m[r])) begin bad++; $display("FAIL rnd%0d_row%0d got=%0d exp=%0d", i, r, o_data[r].Psum_SS, od_m[r]); end
      end
    end
    cycle(0, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    rand_rows(); cycle(1, 0, 0, 1);
    for (int r = 0; r < PEROW; r++) begin ps_in[r] = 0; sm_in[r] = 9 + r; end
    cycle(1, 0, 0, 0);
    rand_rows();
    MS_rdy = 1'b1; ctl.emit = 1'b0; ctl.acc_src = 1'b1;
    #2 i_rstn = 1'b0;
    #1;
    model_reset();
    total++; if (SS_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_ss_rdy got=%b exp=0", SS_rdy); end
    total++; if (o_data !== '0) begin bad++; $display("FAIL rstmid_o_data got=%h exp=0", o_data); end
    total++; if (o_ovf !== '0) begin bad++; $display("FAIL rstmid_o_ovf got=%b exp=0", o_ovf); end
    MS_rdy = 1'b0;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    rand_rows(); cycle(1, 0, 1, 1);
    for (int r = 0; r < PEROW; r++) begin
      total++; if (o_data[r].Psum_SS !== PSUMDWD'(sm_in[r])) begin bad++; $display("FAIL rstmid_first_row%0d got=%0d exp=%0d", r, o_data[r].Psum_SS, sm_in[r]); end
    end
    cycle(0, 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_accumulate();
    test_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
